handshake_monitor: RTL and testbench
====================================

// Module: handshake_monitor
// PURPOSE
//  Parametrised valid/ready protocol monitor, bound non-intrusively onto a DUT with NUM_CH
//  handshake channels. Per channel it checks the protocol rules, flags stalls that exceed a
//  timeout, and counts completed transfers. Sticky error status plus first-error capture go
//  to the bench/scoreboard. Observes only; drives nothing back into the DUT.
// PARAMETERS
//  NUM_CH     4    number of monitored valid/ready channels (1..16)
//  DATA_W     8    payload width per channel, checked for stability while stalled
//  TIMEOUT    16   stall cycles (valid & !ready) that raise a timeout (2..2**CNT_W-1)
//  CNT_W      16   width of stall and transfer counters
// PORTS
//  CLK           in   1              clock, rising edge
//  ASYNCRESETN   in   1              asynchronous active-low reset
//  enable        in   1              1 = checking/counting active; 0 = freeze all state
//  clear         in   1              synchronous clear of sticky errors, counters, capture
//  ch_valid      in   NUM_CH         per-channel valid
//  ch_ready      in   NUM_CH         per-channel ready
//  ch_data       in   NUM_CH*DATA_W  per-channel payload; ch i = [i*DATA_W +: DATA_W]
//  err_pulse     out  NUM_CH         1-cycle pulse: new violation on channel i this cycle
//  err_sticky    out  NUM_CH         latched OR of err_pulse since reset/clear
//  err_code      out  NUM_CH*2       last err_kind_t per channel (pkg enum), held
//  first_err_ch  out  $clog2(NUM_CH) channel of the first error since reset/clear
//  first_err_vld out  1              first_err_ch is valid
//  xfer_count    out  NUM_CH*CNT_W   completed transfers (valid & ready) per channel
//  stall_max     out  NUM_CH*CNT_W   longest stall seen per channel, saturating
// BEHAVIOUR
//  Reset (ASYNCRESETN=0, immediate): all outputs 0, every channel FSM in IDLE, counters 0.
//  Per-channel FSM, registered on CLK; evaluated only when enable=1:
//   IDLE : valid&ready -> IDLE, xfer++. valid&!ready -> STALL, latch data, stall_cnt=1.
//   STALL: valid&ready -> IDLE, xfer++; no data error if data equals latched copy.
//          valid&!ready -> STALL, stall_cnt++ (saturating at 2**CNT_W-1).
//          !valid -> IDLE, raise ERR_DROP (valid withdrawn before ready).
//          data != latched copy while valid -> raise ERR_DATA. Stay in STALL, re-latch.
//          stall_cnt reaches TIMEOUT -> raise ERR_TIMEOUT once per stall episode.
//  A channel holding valid=1 with ready=1 never stalls, so no timeout is possible.
//  Error priority per channel per cycle: DROP > DATA > TIMEOUT; only one code is reported.
//  err_pulse asserts the cycle after the offending sample (1-cycle latency). err_sticky and
//  err_code update on that same edge.
//  stall_max is updated with max(stall_max, stall_cnt) when a stall ends (xfer or drop).
//  xfer_count wraps modulo 2**CNT_W.
//  first_err: captured on the first err_pulse when first_err_vld=0. If several channels err
//  in the same cycle, the lowest index wins. Held until clear.
//  clear=1: zeroes sticky, codes, capture, xfer_count, stall_max. FSMs return to IDLE.
//   If a new error occurs in the same cycle, it is recorded after the clear, so the error
//   wins. enable=0 masks that error.
//  enable=0: state, counters and outputs hold. err_pulse is 0. A stall spanning a disable
//   period does not count the disabled cycles.
//  Async reset mid-stall: FSM goes to IDLE, and no error is raised on reset release.
// STRUCTURE
//  handshake_monitor_pkg: typedef enum logic[1:0] err_kind_t {ERR_NONE, ERR_DROP, ERR_DATA,
//   ERR_TIMEOUT}; typedef enum logic chan_state_t {IDLE, STALL}; localparam-free helpers.
//  Sub-module handshake_monitor_chan (FSM, data latch, stall/xfer counters, one channel) is
//  instantiated NUM_CH times by a generate loop. The top holds the priority encoder for
//  first_err and the clear/enable fan-out.
// TESTING
//  1 ch0: valid&ready for 5 cycles -> xfer_count[0]=5, err_sticky=0, ch0 FSM stays IDLE.
//  2 ch1: valid stall of 3 cycles, data held at 8'hA5, then ready -> xfer_count[1]=1,
//    stall_max[1]=3, no errors.
//  3 ch2: stall, then data 8'h11->8'h22 while !ready -> err_pulse[2] one cycle later,
//    err_code=ERR_DATA, first_err_ch=2.
//  4 ch3 stalled TIMEOUT=16 cycles -> a single ERR_TIMEOUT pulse at the 16th stall cycle+1.
//    No repeat through cycle 40.
//  5 ch1 and ch3 both drop valid in the same cycle -> err_pulse=4'b1010, first_err_ch=1,
//    both err_code=ERR_DROP.
//  6 clear coincides with ch0 error -> err_sticky=4'b0001 after the edge. Assert
//    ASYNCRESETN mid-stall -> all outputs 0 immediately, no pulse after release.

Source files
------------

// File: rtl/handshake_monitor_pkg.sv
// Shared types for the valid/ready handshake monitor.
package handshake_monitor_pkg;

   // Error kinds reported per channel. ERR_NONE doubles as the "no error" code.
   typedef enum logic [1:0] {
      ERR_NONE    = 2'd0,
      ERR_DROP    = 2'd1,
      ERR_DATA    = 2'd2,
      ERR_TIMEOUT = 2'd3
   } err_kind_t;

   // Per-channel protocol state.
   typedef enum logic {
      IDLE  = 1'b0,
      STALL = 1'b1
   } chan_state_t;

endpackage

// File: rtl/handshake_monitor_chan.sv
// One monitored valid/ready channel: protocol FSM, payload latch, stall and
// transfer counters, and the per-channel error status registers.
//
// Handshake: a transfer completes on every enabled clock edge where valid_i
// and ready_i are both high. Once valid_i is raised without ready_i, valid_i
// must stay high and data_i must stay constant until ready_i is seen.
module handshake_monitor_chan
   import handshake_monitor_pkg::*;
#(
   parameter int DATA_W  = 8,
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 16
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              enable_i,
   input  logic              clear_i,
   input  logic              valid_i,
   input  logic              ready_i,
   input  logic [DATA_W-1:0] data_i,
   output logic              err_new_o,
   output logic              err_pulse_o,
   output logic              err_sticky_o,
   output logic [1:0]        err_code_o,
   output logic [CNT_W-1:0]  xfer_count_o,
   output logic [CNT_W-1:0]  stall_max_o,
   output logic              state_o
);

   localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);
   localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT);

   chan_state_t       state_q, state_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              to_done_q, to_done_d;
   logic [CNT_W-1:0]  xfer_q, xfer_d;
   logic [CNT_W-1:0]  smax_q, smax_d;
   logic              pulse_q;
   logic              sticky_q;
   logic [1:0]        code_q;
   err_kind_t         kind;
   logic              err_new;
   logic [CNT_W-1:0]  smax_upd;

   // Longest stall if the current episode ends this cycle.
   assign smax_upd = (cnt_q > smax_q) ? cnt_q : smax_q;

   // Next-state: protocol checks first, then clear overrides the state it owns.
   always_comb begin
      state_d   = state_q;
      data_d    = data_q;
      cnt_d     = cnt_q;
      to_done_d = to_done_q;
      xfer_d    = xfer_q;
      smax_d    = smax_q;
      kind      = ERR_NONE;
      if (enable_i) begin
         case (state_q)
            IDLE: begin
               if (valid_i && ready_i) begin
                  xfer_d = xfer_q + ONE;
               end else if (valid_i) begin
                  state_d   = STALL;
                  data_d    = data_i;
                  cnt_d     = ONE;
                  to_done_d = 1'b0;
               end
            end
            STALL: begin
               if (!valid_i) begin
                  // Valid withdrawn before ready: highest priority error.
                  kind    = ERR_DROP;
                  state_d = IDLE;
                  smax_d  = smax_upd;
                  cnt_d   = '0;
               end else begin
                  if (data_i != data_q) kind = ERR_DATA;
                  if (ready_i) begin
                     state_d = IDLE;
                     xfer_d  = xfer_q + ONE;
                     smax_d  = smax_upd;
                     cnt_d   = '0;
                  end else begin
                     data_d = data_i;
                     cnt_d  = (cnt_q == '1) ? cnt_q : cnt_q + ONE;
                     // Timeout reported once per episode, and only if nothing stronger fired.
                     if (kind == ERR_NONE && !to_done_q && cnt_d >= TO_VAL) begin
                        kind      = ERR_TIMEOUT;
                        to_done_d = 1'b1;
                     end
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end
      if (clear_i) begin
         state_d   = IDLE;
         cnt_d     = '0;
         to_done_d = 1'b0;
         xfer_d    = '0;
         smax_d    = '0;
      end
   end

   assign err_new = (kind != ERR_NONE);

   // FSM, latch and counter registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= IDLE;
         data_q    <= '0;
         cnt_q     <= '0;
         to_done_q <= 1'b0;
         xfer_q    <= '0;
         smax_q    <= '0;
      end else begin
         state_q   <= state_d;
         data_q    <= data_d;
         cnt_q     <= cnt_d;
         to_done_q <= to_done_d;
         xfer_q    <= xfer_d;
         smax_q    <= smax_d;
      end
   end

   // Error status: a new error on a clear cycle lands after the clear.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         pulse_q  <= 1'b0;
         sticky_q <= 1'b0;
         code_q   <= ERR_NONE;
      end else begin
         pulse_q  <= err_new;
         sticky_q <= (sticky_q & ~clear_i) | err_new;
         if (err_new)      code_q <= kind;
         else if (clear_i) code_q <= ERR_NONE;
      end
   end

   assign err_new_o    = err_new;
   assign err_pulse_o  = pulse_q;
   assign err_sticky_o = sticky_q;
   assign err_code_o   = code_q;
   assign xfer_count_o = xfer_q;
   assign stall_max_o  = smax_q;
   assign state_o      = state_q;

endmodule

// File: rtl/handshake_monitor.sv
// Non-intrusive valid/ready protocol monitor for NUM_CH channels. Per-channel
// checking lives in handshake_monitor_chan; this level packs the outputs and
// captures the first erroring channel (lowest index wins on a tie).
module handshake_monitor
   import handshake_monitor_pkg::*;
#(
   parameter  int NUM_CH  = 4,
   parameter  int DATA_W  = 8,
   parameter  int TIMEOUT = 16,
   parameter  int CNT_W   = 16,
   localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                     CLK,
   input  logic                     ASYNCRESETN,
   input  logic                     enable,
   input  logic                     clear,
   input  logic [NUM_CH-1:0]        ch_valid,
   input  logic [NUM_CH-1:0]        ch_ready,
   input  logic [NUM_CH*DATA_W-1:0] ch_data,
   output logic [NUM_CH-1:0]        err_pulse,
   output logic [NUM_CH-1:0]        err_sticky,
   output logic [NUM_CH*2-1:0]      err_code,
   output logic [CH_W-1:0]          first_err_ch,
   output logic                     first_err_vld,
   output logic [NUM_CH*CNT_W-1:0]  xfer_count,
   output logic [NUM_CH*CNT_W-1:0]  stall_max,
   output logic [NUM_CH-1:0]        dbg_state_o
);

   logic [NUM_CH-1:0] err_new;
   logic [CH_W-1:0]   first_idx;
   logic              fe_vld_q, fe_vld_d;
   logic [CH_W-1:0]   fe_ch_q, fe_ch_d;

   for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
      handshake_monitor_chan #(
         .DATA_W  (DATA_W),
         .TIMEOUT (TIMEOUT),
         .CNT_W   (CNT_W)
      ) u_chan (
         .clk_i        (CLK),
         .rst_ni       (ASYNCRESETN),
         .enable_i     (enable),
         .clear_i      (clear),
         .valid_i      (ch_valid[i]),
         .ready_i      (ch_ready[i]),
         .data_i       (ch_data[i*DATA_W +: DATA_W]),
         .err_new_o    (err_new[i]),
         .err_pulse_o  (err_pulse[i]),
         .err_sticky_o (err_sticky[i]),
         .err_code_o   (err_code[i*2 +: 2]),
         .xfer_count_o (xfer_count[i*CNT_W +: CNT_W]),
         .stall_max_o  (stall_max[i*CNT_W +: CNT_W]),
         .state_o      (dbg_state_o[i])
      );
   end

   // Lowest-index channel among those raising an error this cycle.
   always_comb begin
      first_idx = '0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (err_new[i]) first_idx = CH_W'(i);
      end
   end

   // First-error capture; an error coincident with clear is kept.
   always_comb begin
      fe_vld_d = fe_vld_q;
      fe_ch_d  = fe_ch_q;
      if (clear) begin
         fe_vld_d = 1'b0;
         fe_ch_d  = '0;
      end
      if (!fe_vld_d && (|err_new)) begin
         fe_vld_d = 1'b1;
         fe_ch_d  = first_idx;
      end
   end

   // First-error registers, updated on the same edge as err_pulse.
   always_ff @(posedge CLK or negedge ASYNCRESETN) begin
      if (!ASYNCRESETN) begin
         fe_vld_q <= 1'b0;
         fe_ch_q  <= '0;
      end else begin
         fe_vld_q <= fe_vld_d;
         fe_ch_q  <= fe_ch_d;
      end
   end

   assign first_err_vld = fe_vld_q;
   assign first_err_ch  = fe_ch_q;

endmodule

// File: tb/tb_handshake_monitor.sv
// Directed bench for handshake_monitor with hand-computed expectations.
module tb_handshake_monitor;

   localparam int NUM_CH = 4;
   localparam int DATA_W = 8;
   localparam int CNT_W  = 16;

   logic                     CLK = 1'b0;
   logic                     ASYNCRESETN;
   logic                     enable;
   logic                     clear;
   logic [NUM_CH-1:0]        ch_valid;
   logic [NUM_CH-1:0]        ch_ready;
   logic [NUM_CH*DATA_W-1:0] ch_data;
   logic [NUM_CH-1:0]        err_pulse;
   logic [NUM_CH-1:0]        err_sticky;
   logic [NUM_CH*2-1:0]      err_code;
   logic [1:0]               first_err_ch;
   logic                     first_err_vld;
   logic [NUM_CH*CNT_W-1:0]  xfer_count;
   logic [NUM_CH*CNT_W-1:0]  stall_max;
   logic [NUM_CH-1:0]        dbg_state;

   int n_cmp = 0;
   int n_err = 0;

   handshake_monitor #(
      .NUM_CH  (NUM_CH),
      .DATA_W  (DATA_W),
      .TIMEOUT (16),
      .CNT_W   (CNT_W)
   ) dut (
      .CLK           (CLK),
      .ASYNCRESETN   (ASYNCRESETN),
      .enable        (enable),
      .clear         (clear),
      .ch_valid      (ch_valid),
      .ch_ready      (ch_ready),
      .ch_data       (ch_data),
      .err_pulse     (err_pulse),
      .err_sticky    (err_sticky),
      .err_code      (err_code),
      .first_err_ch  (first_err_ch),
      .first_err_vld (first_err_vld),
      .xfer_count    (xfer_count),
      .stall_max     (stall_max),
      .dbg_state_o   (dbg_state)
   );

   // Clock
   always #5 CLK = ~CLK;

   function automatic logic [CNT_W-1:0] xc(input int i);
      return xfer_count[i*CNT_W +: CNT_W];
   endfunction

   function automatic logic [CNT_W-1:0] sm(input int i);
      return stall_max[i*CNT_W +: CNT_W];
   endfunction

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      ASYNCRESETN = 1'b0;
      enable      = 1'b1;
      clear       = 1'b0;
      ch_valid    = '0;
      ch_ready    = '0;
      ch_data     = '0;
      #12;
      // Reset state
      chk("rst_pulse",  err_pulse, 0);
      chk("rst_sticky", err_sticky, 0);
      chk("rst_code",   err_code, 0);
      chk("rst_fevld",  first_err_vld, 0);
      chk("rst_xfer",   xfer_count, 0);
      chk("rst_smax",   stall_max, 0);
      chk("rst_state",  dbg_state, 0);
      ASYNCRESETN = 1'b1;
      step();

      // 1: ch0 back-to-back transfers
      ch_valid[0] = 1'b1; ch_ready[0] = 1'b1;
      repeat (5) step();
      chk("t1_xfer0",   xc(0), 5);
      chk("t1_sticky",  err_sticky, 0);
      chk("t1_state0",  dbg_state[0], 0);
      ch_valid[0] = 1'b0; ch_ready[0] = 1'b0;
      step();
      chk("t1_xfer0_hold", xc(0), 5);

      // 2: ch1 stall of 3 cycles with stable data, then accepted
      ch_data[1*8 +: 8] = 8'hA5; ch_valid[1] = 1'b1;
      repeat (3) step();
      chk("t2_state1", dbg_state[1], 1);
      chk("t2_smax1_pre", sm(1), 0);
      ch_ready[1] = 1'b1;
      step();
      chk("t2_xfer1",  xc(1), 1);
      chk("t2_smax1",  sm(1), 3);
      chk("t2_sticky", err_sticky, 0);
      chk("t2_state1_idle", dbg_state[1], 0);
      ch_valid[1] = 1'b0; ch_ready[1] = 1'b0;
      step();

      // 3: ch2 data changes while stalled
      ch_data[2*8 +: 8] = 8'h11; ch_valid[2] = 1'b1;
      step();
      ch_data[2*8 +: 8] = 8'h22;
      step();
      chk("t3_pulse",  err_pulse, 4'b0100);
      chk("t3_code2",  err_code[5:4], 2);
      chk("t3_fevld",  first_err_vld, 1);
      chk("t3_fech",   first_err_ch, 2);
      chk("t3_sticky", err_sticky, 4'b0100);
      chk("t3_state2", dbg_state[2], 1);
      step();
      chk("t3_pulse_once", err_pulse, 0);
      ch_ready[2] = 1'b1;
      step();
      chk("t3_xfer2", xc(2), 1);
      chk("t3_smax2", sm(2), 3);
      chk("t3_no_err_on_accept", err_pulse, 0);
      ch_valid[2] = 1'b0; ch_ready[2] = 1'b0;
      step();

      // 4: ch3 long stall, single timeout at the 16th stall sample
      ch_data[3*8 +: 8] = 8'h33; ch_valid[3] = 1'b1;
      for (int k = 1; k <= 40; k++) begin
         step();
         chk($sformatf("t4_pulse_k%0d", k), err_pulse, (k == 16) ? 4'b1000 : 4'b0000);
      end
      chk("t4_code3",   err_code[7:6], 3);
      chk("t4_sticky",  err_sticky, 4'b1100);
      chk("t4_fech",    first_err_ch, 2);

      // clear while ch3 is still stalled and ch1 raises valid
      clear = 1'b1; ch_data[1*8 +: 8] = 8'h5A; ch_valid[1] = 1'b1;
      step();
      clear = 1'b0;
      chk("clr_sticky", err_sticky, 0);
      chk("clr_code",   err_code, 0);
      chk("clr_fevld",  first_err_vld, 0);
      chk("clr_xfer",   xfer_count, 0);
      chk("clr_smax",   stall_max, 0);
      chk("clr_state",  dbg_state, 0);

      // 5: ch1 and ch3 drop valid in the same cycle
      step();
      chk("t5_state", dbg_state, 4'b1010);
      ch_valid[1] = 1'b0; ch_valid[3] = 1'b0;
      step();
      chk("t5_pulse",  err_pulse, 4'b1010);
      chk("t5_fech",   first_err_ch, 1);
      chk("t5_fevld",  first_err_vld, 1);
      chk("t5_code",   err_code, 8'b01_00_01_00);
      chk("t5_smax3",  sm(3), 1);
      chk("t5_state_idle", dbg_state, 0);
      step();

      // enable=0 freezes a stall on ch2 and masks its violations
      ch_data[2*8 +: 8] = 8'h55; ch_valid[2] = 1'b1;
      repeat (2) step();
      enable = 1'b0; ch_data[2*8 +: 8] = 8'h66;
      step();
      ch_valid[2] = 1'b0;
      repeat (2) step();
      chk("dis_pulse",  err_pulse, 0);
      chk("dis_state2", dbg_state[2], 1);
      chk("dis_sticky", err_sticky, 4'b1010);
      enable = 1'b1; ch_valid[2] = 1'b1; ch_data[2*8 +: 8] = 8'h55; ch_ready[2] = 1'b1;
      step();
      chk("dis_xfer2", xc(2), 1);
      chk("dis_smax2", sm(2), 2);
      chk("dis_noerr", err_pulse, 0);
      ch_valid[2] = 1'b0; ch_ready[2] = 1'b0;
      step();

      // 6: clear coincides with a ch0 drop
      ch_data[7:0] = 8'h44; ch_valid[0] = 1'b1;
      step();
      clear = 1'b1; ch_valid[0] = 1'b0;
      step();
      clear = 1'b0;
      chk("t6_sticky", err_sticky, 4'b0001);
      chk("t6_pulse",  err_pulse, 4'b0001);
      chk("t6_code",   err_code, 8'h01);
      chk("t6_fevld",  first_err_vld, 1);
      chk("t6_fech",   first_err_ch, 0);

      // async reset mid-stall on ch3
      ch_valid[3] = 1'b1;
      step();
      chk("t6_state3", dbg_state[3], 1);
      #2 ASYNCRESETN = 1'b0;
      #1;
      chk("ar_sticky", err_sticky, 0);
      chk("ar_fevld",  first_err_vld, 0);
      chk("ar_state",  dbg_state, 0);
      chk("ar_code",   err_code, 0);
      ch_valid[3] = 1'b0;
      #2 ASYNCRESETN = 1'b1;
      step();
      chk("ar_pulse_after", err_pulse, 0);
      step();
      chk("ar_sticky_after", err_sticky, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
